// File: rtl/victim_write_buffer.sv
// -----------------------------------------------------------------------------
// victim_write_buffer
//
// FIFO write buffer between the cache controller's dirty-eviction path and the
// backing RAM. Evicted lines (one word each) are accepted in a single cycle and
// drained to the RAM in FIFO order by a two-state drain FSM. A combinational
// lookup port lets a refill pick up the newest pending data for an address that
// has not reached the RAM yet.
//
// Optional feature (compile-time macro VWB_COALESCE_EN):
//   When defined, a victim whose address matches a pending entry that is not
//   currently being written to the RAM overwrites that entry's data in place
//   instead of taking a new slot. This is also accepted while the buffer is full.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-low reset
//   evict_valid    controller presents a dirty victim
//   evict_addr     victim word address
//   evict_data     victim data
//   evict_ready    buffer can accept (transfer on evict_valid && evict_ready)
//   lk_addr        refill lookup address
//   lk_hit         lookup address matches a pending entry (combinational)
//   lk_data        data of the youngest matching entry, 0 on miss
//   mem_write_en   RAM write request
//   mem_address    RAM write address
//   mem_write_data RAM write data
//   mem_ready      RAM accepted the write this cycle
//   wb_empty       no pending entries and drain FSM idle
//   wb_count       number of pending entries
// -----------------------------------------------------------------------------
module victim_write_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      evict_valid,
    input  logic [ADDR_WIDTH-1:0]     evict_addr,
    input  logic [DATA_WIDTH-1:0]     evict_data,
    output logic                      evict_ready,
    input  logic [ADDR_WIDTH-1:0]     lk_addr,
    output logic                      lk_hit,
    output logic [DATA_WIDTH-1:0]     lk_data,
    output logic                      mem_write_en,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic [DATA_WIDTH-1:0]     mem_write_data,
    input  logic                      mem_ready,
    output logic                      wb_empty,
    output logic [$clog2(DEPTH):0]    wb_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Storage: addresses/data are plain registers because every entry is
    // compared in parallel for lookup and coalescing.
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;

    logic [PTR_W-1:0]      w_count;
    logic                  w_full;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_coal_head;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [DEPTH-1:0]      w_coal_we;
    logic [DEPTH-1:0]      w_entry_we;
    logic [DEPTH-1:0]      w_push_mask;
    logic [DEPTH-1:0]      w_pop_mask;
    logic [DEPTH-1:0]      w_lk_match;
    logic [IDX_W-1:0]      w_ofs_idx [DEPTH];
    logic                  w_lk_hit;
    logic [DATA_WIDTH-1:0] w_lk_data;

    // The MSB of the pointers separates full from empty.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == PTR_W'(DEPTH));
    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

    // Per-entry decode. w_ofs_idx[k] is the slot holding the k-th oldest entry,
    // so scanning k upwards visits entries from oldest to youngest.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_ofs_idx[gi]   = w_rd_idx + IDX_W'(gi);
            assign w_lk_match[gi]  = r_valid[gi] && (r_addr[gi] == lk_addr);
            assign w_push_mask[gi] = w_push && (w_wr_idx == IDX_W'(gi));
            assign w_pop_mask[gi]  = w_pop && (w_rd_idx == IDX_W'(gi));
            assign w_entry_we[gi]  = w_push_mask[gi] || w_coal_we[gi];
        end
    endgenerate

    // Lookup: the last match in oldest-to-youngest order wins.
    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_lk_match[w_ofs_idx[k]]) begin
                w_lk_hit  = 1'b1;
                w_lk_data = r_data[w_ofs_idx[k]];
            end
        end
    end

    assign lk_hit  = w_lk_hit;
    assign lk_data = w_lk_data;

`ifdef VWB_COALESCE_EN
    // The head entry is frozen while its write is on the bus; any other
    // pending entry (or the head while idle) may absorb a matching victim.
    logic [DEPTH-1:0] w_coal_elig;
    logic             w_coal_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_coal
            assign w_coal_elig[gi] = r_valid[gi] && (r_addr[gi] == evict_addr) &&
                                     !((r_state == ST_WRITE) && (w_rd_idx == IDX_W'(gi)));
        end
    endgenerate

    always_comb begin
        w_coal_we  = '0;
        w_coal_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_coal_elig[w_ofs_idx[k]]) begin
                w_coal_we                 = '0;
                w_coal_we[w_ofs_idx[k]]   = evict_valid;
                w_coal_hit                = 1'b1;
            end
        end
    end

    assign evict_ready = !w_full || w_coal_hit;
`else
    assign w_coal_we   = '0;
    assign evict_ready = !w_full;
`endif

    assign w_push      = evict_valid && evict_ready && (w_coal_we == '0);
    assign w_coal_head = w_coal_we[w_rd_idx];
    // If the idle head is being coalesced on the same edge the FSM loads it,
    // the bus must carry the new data, not the value about to be overwritten.
    assign w_head_data = w_coal_head ? evict_data : r_data[w_rd_idx];

    // Entry payload: no reset needed, validity is tracked by r_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_we[i]) begin
                r_addr[i] <= evict_addr;
                r_data[i] <= evict_data;
            end
        end
    end

    // Pointers, valid bits and the RAM request registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_valid    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_valid <= (r_valid & ~w_pop_mask) | w_push_mask;
            if (w_load) begin
                r_mem_addr <= r_addr[w_rd_idx];
                r_mem_data <= w_head_data;
            end
        end
    end

    // Drain FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Drain FSM: next state. Returning to IDLE after every pop guarantees at
    // least one cycle with mem_write_en low between writes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_count != '0) w_state_next = ST_WRITE;
            ST_WRITE: if (mem_ready)     w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // Drain FSM: outputs.
    always_comb begin
        mem_write_en = 1'b0;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = (w_count != '0);
            end
            ST_WRITE: begin
                mem_write_en = 1'b1;
                w_pop        = mem_ready;
            end
            default: begin
                mem_write_en = 1'b0;
            end
        endcase
    end

    assign mem_address    = r_mem_addr;
    assign mem_write_data = r_mem_data;
    assign wb_empty       = (w_count == '0) && (r_state == ST_IDLE);
    assign wb_count       = w_count;

endmodule

// File: doc/victim_write_buffer.md
Name: victim_write_buffer

Overview:
- FIFO write buffer between the cache controller's dirty-eviction path and the backing RAM.
- Accepts evicted dirty lines (one word per line, word-addressed like the RAM) in a single cycle, so a miss refill does not wait behind a write-back.
- Drains entries to the RAM in FIFO order.
- Gives the controller a same-cycle lookup port, so a refill from an address still pending in the buffer gets the newest data.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 16, word address width (matches RAM index).
- DEPTH, 4, number of buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- evict_valid  in  1  controller presents a dirty victim.
- evict_addr  in  ADDR_WIDTH  victim word address.
- evict_data  in  DATA_WIDTH  victim data.
- evict_ready  out  1  buffer can accept; transfer occurs when evict_valid && evict_ready at the clock edge.
- lk_addr  in  ADDR_WIDTH  refill lookup address.
- lk_hit  out  1  combinational: lk_addr matches a valid entry.
- lk_data  out  DATA_WIDTH  combinational: data of the youngest matching entry; 0 when no hit.
- mem_write_en  out  1  write request to RAM.
- mem_address  out  ADDR_WIDTH  RAM write address.
- mem_write_data  out  DATA_WIDTH  RAM write data.
- mem_ready  in  1  RAM accepted/completed the write this cycle.
- wb_empty  out  1  no valid entries and drain FSM idle.
- wb_count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage:
  - Circular FIFO with read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH.
- Reset (rst==0 at an edge):
  - Pointers 0, all entries invalid, FSM IDLE.
  - Outputs next cycle: mem_write_en=0, mem_address=0, mem_write_data=0, evict_ready=1, wb_empty=1, wb_count=0, lk_hit=0.
  - Reset mid-write abandons the in-flight write and discards buffered data; the RAM is left unchanged by the abandoned write.
- Enqueue:
  - evict_ready = !full, computed from registered state only.
  - When full, no enqueue occurs even if a pop happens the same cycle; evict_ready returns to 1 the cycle after the pop.
  - An accepted entry is visible to lookup and to the drain FSM from the next cycle; there is no same-cycle bypass.
- Drain FSM:
  - IDLE: if count>0, go to WRITE at the next edge; mem_address and mem_write_data are loaded from the head entry.
  - WRITE: mem_write_en=1 with address/data held stable. When mem_ready=1 at an edge, pop the head and return to IDLE. mem_write_en drops for at least one cycle between consecutive writes.
  - mem_ready is ignored in IDLE.
- Simultaneous enqueue and pop in the same cycle: count unchanged; both pointers advance.
- Lookup:
  - Compares lk_addr against all valid entries, including the head while it is in WRITE; head data remains valid until the pop.
  - Multiple matches return the youngest entry (closest to the write pointer).
- wb_count: updated every edge as enqueue minus pop; never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: VWB_COALESCE_EN.
- Defined:
  - An accepted victim whose address matches a valid non-head entry (or the head while the FSM is IDLE) overwrites that entry's data in place. No new slot is used and count is unchanged.
  - A matching head while in WRITE is never modified; the victim is enqueued as a new entry.
  - Coalescing is accepted even when full if a match exists: evict_ready = !full || match.
- Undefined: every accepted victim occupies a new entry; evict_ready = !full.

Test Plan:
- Reset then idle:
  - Hold rst=0 for 2 cycles, release.
  - Expect evict_ready=1, wb_empty=1, wb_count=0, mem_write_en=0, lk_hit=0 for lk_addr=0x5000.
- Single drain:
  - Enqueue 0x5000/0xDEADBEEF; RAM asserts mem_ready 3 cycles after mem_write_en rises.
  - Expect mem_address=0x5000 and mem_write_data=0xDEADBEEF held stable throughout WRITE.
  - Expect RAM mem[0x5000]=0xDEADBEEF, then wb_empty=1.
- Full back-pressure:
  - Hold mem_ready=0 and enqueue 0x1000, 0x2000, 0x3000, 0x4000, then present 0x6000.
  - Expect evict_ready=0 and wb_count=4, 0x6000 not accepted.
  - After one mem_ready pulse, 0x6000 is accepted; drain order at the RAM is 0x1000, 0x2000, 0x3000, 0x4000, 0x6000.
- Lookup forwarding:
  - With 0x5000/0xDEADBEEF pending, lk_addr=0x5000 gives lk_hit=1, lk_data=0xDEADBEEF in the same cycle; lk_addr=0x5001 gives lk_hit=0, lk_data=0.
  - After the pop, lk_addr=0x5000 gives lk_hit=0.
- Duplicate address:
  - Stall the RAM and enqueue 0x5000/0x11111111, then 0x5000/0x22222222. Lookup returns 0x22222222 in both builds.
  - Without VWB_COALESCE_EN: wb_count=2, and the RAM sees two writes, last value 0x22222222.
  - With VWB_COALESCE_EN and the FSM IDLE at the second enqueue: wb_count=1 and a single write of 0x22222222.
- Reset mid-write:
  - Assert rst=0 while in WRITE with 3 entries.
  - Next cycle: mem_write_en=0, wb_count=0, evict_ready=1.
  - No further RAM writes occur until a new evict.
